// File: rtl/integrator_chain.sv
// Cascaded integrator stack for a CIC interpolator; accumulates after the upsampler's start flag.
// Optional build macro INTEGRATOR_CHAIN_ROUND_EN selects round-half-up instead of truncation.
module integrator_chain #(
    parameter int unsigned gp_data_width = 8,
    parameter int unsigned gp_nr_stages  = 4,
    parameter int unsigned gp_rate       = 4,
    parameter int unsigned gp_out_width  = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_an,
    input  logic                     i_ena,
    input  logic [gp_data_width-1:0] i_data,
    input  logic                     i_start,
    output logic [gp_out_width-1:0]  o_data,
    output logic                     o_valid
);

    localparam int unsigned AccW = gp_data_width + gp_nr_stages * $clog2(gp_rate);
    localparam int unsigned CntW = $clog2(gp_nr_stages + 2);
    localparam logic [CntW-1:0] FillMax = CntW'(gp_nr_stages + 1);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    logic [0:0]              state_q, state_d;
    logic [AccW-1:0]         acc_q [gp_nr_stages];
    logic [AccW-1:0]         acc_d [gp_nr_stages];
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [gp_out_width-1:0] out_q, out_d;
    logic                    valid_q, valid_d;

    logic                    acc_en;
    logic [AccW-1:0]         data_ext;
    logic [AccW-1:0]         acc_last;
    logic [gp_out_width-1:0] out_sel;

    // The cycle that first sees i_start already accumulates.
    assign acc_en   = i_ena & ((state_q == StRun) | i_start);
    assign data_ext = {{(AccW - gp_data_width){i_data[gp_data_width-1]}}, i_data};

`ifdef INTEGRATOR_CHAIN_ROUND_EN
    function automatic logic [AccW-1:0] round_inc();
        logic [AccW-1:0] r;
        r = '0;
        for (int i = 0; i < AccW; i++) begin
            if (i == int'(AccW) - int'(gp_out_width) - 1) r[i] = 1'b1;
        end
        return r;
    endfunction

    localparam logic [AccW-1:0] RoundInc = round_inc();

    assign acc_last = acc_q[gp_nr_stages-1] + RoundInc;
`else
    assign acc_last = acc_q[gp_nr_stages-1];
`endif

    assign out_sel = gp_out_width'(acc_last >> (AccW - gp_out_width));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        valid_d = valid_q;
        if (acc_en) begin
            state_d  = StRun;
            acc_d[0] = acc_q[0] + data_ext;
            // Each stage adds the previous stage's registered value, one cycle behind.
            for (int k = 1; k < gp_nr_stages; k++) begin
                acc_d[k] = acc_q[k] + acc_q[k-1];
            end
            out_d = out_sel;
            if (cnt_q != FillMax) cnt_d = cnt_q + CntW'(1);
            valid_d = valid_q | (cnt_d == FillMax);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            state_q <= StIdle;
            for (int k = 0; k < gp_nr_stages; k++) acc_q[k] <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign o_data  = out_q;
    assign o_valid = valid_q;

endmodule

// File: tb/tb_integrator_chain.sv
// Bench for integrator_chain: three instances checked every cycle against a closed-form
// binomial model of the integrator cascade, plus literal checkpoints.
module tb_integrator_chain;

    localparam int MaxLen = 1024;
`ifdef INTEGRATOR_CHAIN_ROUND_EN
    localparam bit     Rnd    = 1'b1;
    localparam longint RndPos = 2;
    localparam longint RndNeg = -1;
`else
    localparam bit     Rnd    = 1'b0;
    localparam longint RndPos = 1;
    localparam longint RndNeg = -2;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic ena;
    logic start0, start1, start2;
    logic [7:0] data0, data1, data2;
    logic [13:0] o0;
    logic [9:0]  o1;
    logic [7:0]  o2;
    logic v0, v1, v2;

    int total = 0;
    int bad   = 0;

    longint xs [3][MaxLen];
    int     nx [3];
    bit     started [3];

    always #5 clk = ~clk;

    // u0: N=3, A=14, out=14
    integrator_chain #(
        .gp_data_width(8), .gp_nr_stages(3), .gp_rate(4), .gp_out_width(14)
    ) u0 (
        .i_clk(clk), .i_rst_an(rst_n), .i_ena(ena), .i_data(data0), .i_start(start0),
        .o_data(o0), .o_valid(v0)
    );

    // u1: N=1, A=10, out=10 (wrap)
    integrator_chain #(
        .gp_data_width(8), .gp_nr_stages(1), .gp_rate(4), .gp_out_width(10)
    ) u1 (
        .i_clk(clk), .i_rst_an(rst_n), .i_ena(ena), .i_data(data1), .i_start(start1),
        .o_data(o1), .o_valid(v1)
    );

    // u2: N=1, A=10, out=8 (LSBs discarded)
    integrator_chain #(
        .gp_data_width(8), .gp_nr_stages(1), .gp_rate(4), .gp_out_width(8)
    ) u2 (
        .i_clk(clk), .i_rst_an(rst_n), .i_ena(ena), .i_data(data2), .i_start(start2),
        .o_data(o2), .o_valid(v2)
    );

    task automatic check(input string name, input logic signed [63:0] got,
                         input longint want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
        end
    endtask

    function automatic longint binom(int n, int k);
        longint c = 1;
        if (n < k || n < 0) return 0;
        for (int r = 1; r <= k; r++) c = c * longint'(n - k + r) / longint'(r);
        return c;
    endfunction

    // Output after j+1 accumulating edges: sum_i C(j-1-i, N-1) * x[i], i <= j-N,
    // wrapped to A bits, optionally rounded, then the top out bits as signed.
    function automatic longint exp_out(int idx, int n_st, int a_w, int o_w, bit rnd);
        longint acc  = 0;
        longint top;
        longint mask = (longint'(1) << a_w) - 1;
        int     j    = nx[idx] - 1;
        for (int i = 0; i <= j - n_st; i++) acc += binom(j - 1 - i, n_st - 1) * xs[idx][i];
        acc = acc & mask;
        if (rnd && o_w < a_w) acc = (acc + (longint'(1) << (a_w - o_w - 1))) & mask;
        top = acc >> (a_w - o_w);
        if (top[o_w-1]) top = top - (longint'(1) << o_w);
        return top;
    endfunction

    function automatic longint exp_valid(int idx, int n_st);
        return (nx[idx] >= n_st + 1) ? 1 : 0;
    endfunction

    task automatic push(input int idx, input logic s, input logic [7:0] d);
        if (started[idx] || s) begin
            started[idx] <= 1'b1;
            if (nx[idx] < MaxLen) begin
                xs[idx][nx[idx]] <= longint'($signed(d));
                nx[idx]          <= nx[idx] + 1;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                nx[i]      <= 0;
                started[i] <= 1'b0;
            end
        end else if (ena) begin
            push(0, start0, data0);
            push(1, start1, data1);
            push(2, start2, data2);
        end
    end

    always @(negedge clk) begin
        check("u0 data",  $signed(o0), exp_out(0, 3, 14, 14, Rnd));
        check("u0 valid", {63'd0, v0}, exp_valid(0, 3));
        check("u1 data",  $signed(o1), exp_out(1, 1, 10, 10, Rnd));
        check("u1 valid", {63'd0, v1}, exp_valid(1, 1));
        check("u2 data",  $signed(o2), exp_out(2, 1, 10, 8, Rnd));
        check("u2 valid", {63'd0, v2}, exp_valid(2, 1));
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        data0 = 8'd0; data1 = 8'd0; data2 = 8'd0;
        repeat (3) cyc();
        check("reset data", $signed(o0), 0);
        check("reset valid", {63'd0, v0}, 0);
        rst_n = 1'b1;
        cyc();

        // start gating
        ena = 1'b1; data0 = 8'd5;
        repeat (10) cyc();
        check("gate data", $signed(o0), 0);
        check("gate valid", {63'd0, v0}, 0);

        // impulse
        start0 = 1'b1; data0 = 8'd1;
        cyc();
        start0 = 1'b0; data0 = 8'd0;
        repeat (2) cyc();
        check("imp valid c3", {63'd0, v0}, 0);
        cyc();
        check("imp c4", $signed(o0), 1);
        check("imp valid c4", {63'd0, v0}, 1);
        cyc();
        check("imp c5", $signed(o0), 3);
        cyc();
        check("imp c6", $signed(o0), 6);

        // enable stall
        ena = 1'b0;
        repeat (7) cyc();
        check("stall data", $signed(o0), 6);
        check("stall valid", {63'd0, v0}, 1);
        ena = 1'b1;
        cyc();
        check("resume c7", $signed(o0), 10);
        cyc();
        check("resume c8", $signed(o0), 15);

        // wrap
        start1 = 1'b1; data1 = 8'd127;
        cyc();
        start1 = 1'b0;
        repeat (4) cyc();
        check("wrap 508", $signed(o1), 508);
        cyc();
        check("wrap -389", $signed(o1), -389);

        // rounding / truncation
        start2 = 1'b1; data2 = 8'd6;
        cyc();
        start2 = 1'b0; data2 = 8'd0;
        cyc();
        check("round pos", $signed(o2), RndPos);
        data2 = 8'hf4;
        cyc();
        data2 = 8'd0;
        cyc();
        check("round neg", $signed(o2), RndNeg);

        // random run
        repeat (120) begin
            ena   = ($urandom_range(0, 3) != 0);
            data0 = 8'($urandom);
            data1 = 8'($urandom);
            data2 = 8'($urandom);
            cyc();
        end

        // asynchronous reset mid-run
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst o0", $signed(o0), 0);
        check("async rst v0", {63'd0, v0}, 0);
        check("async rst o1", $signed(o1), 0);
        check("async rst o2", $signed(o2), 0);
        cyc();
        rst_n = 1'b1;
        ena = 1'b1;
        repeat (8) begin
            data0 = 8'($urandom);
            cyc();
        end
        check("no restart data", $signed(o0), 0);
        check("no restart valid", {63'd0, v0}, 0);

        repeat (250) begin
            ena    = ($urandom_range(0, 4) != 0);
            start0 = ($urandom_range(0, 15) == 0);
            start1 = ($urandom_range(0, 15) == 0);
            start2 = ($urandom_range(0, 15) == 0);
            data0  = 8'($urandom);
            data1  = 8'($urandom);
            data2  = 8'($urandom);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
